seven_segment_scan: RTL
=======================

Name: seven_segment_scan

Overview:
Parametrised time-multiplexed hex display driver for NUM_DIGITS common-anode seven-segment digits sharing one segment bus.
- Latches a multi-digit hex value through a load strobe.
- Applies new values only at frame boundaries, so the display never tears mid-frame.
- Scans digits at a programmable rate and supports leading-zero blanking.
- Sits between the datapath or student-ID logic and the board's segment and anode pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (legal 1..8)
CLK_DIV, 50000, clk cycles per digit slot (legal >= 2)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
load  input  1  single-cycle strobe; captures value and dp_in
value  input  4*NUM_DIGITS  hex nibbles; nibble 0 = rightmost digit
dp_in  input  NUM_DIGITS  decimal point per digit, 1 = lit
blank_lz  input  1  1 = blank leading zeros (level, sampled every cycle)
seg  output  7  active-low segments; bit0 = a ... bit6 = g
dp  output  1  active-low decimal point
an  output  NUM_DIGITS  active-low digit enables
frame_done  output  1  one-cycle pulse at each frame boundary

Behaviour:
- Reset, synchronous: next clk edge with rst=1 forces the following.
  - Outputs: seg=7'h7F, dp=1, an=all 1, frame_done=0.
  - Internal state: prescaler=0, digit index=0, pending and shadow registers=0.
  - A load asserted with rst is ignored. Mid-operation reset discards any pending load.
- Prescaler: counts 0..CLK_DIV-1; the terminal count is the "tick".
- Digit index: advances on each tick, wrapping NUM_DIGITS-1 -> 0. The tick causing that wrap is the frame boundary.
- Guard cycle: in the cycle after each tick, an=all 1 (anti-ghosting). From the following cycle until the next tick's guard, an has only bit[idx] low.
- seg/dp: registered, valid 1 cycle after the index changes (during the guard), stable for the rest of the slot.
- Font, 7-bit active-low: 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 B:03 C:46 D:21 E:06 F:0E (hex).
- Load path:
  - load=1 copies value/dp_in into the pending register and sets pending_valid.
  - At a frame boundary with pending_valid, pending moves to shadow and pending_valid clears.
  - Several loads within one frame: last wins.
  - load on the same cycle as a frame boundary: value bypasses straight to shadow; pending_valid ends 0.
  - Display always reads shadow.
- frame_done: 1 for exactly the cycle after the frame-boundary tick.
- Leading-zero blanking (blank_lz=1):
  - Digit k is blanked when k != 0 and all shadow nibbles k..NUM_DIGITS-1 are 0.
  - A blanked digit drives seg=7'h7F; its dp still follows shadow dp.
  - Digit 0 is never blanked, so value 0 shows a single "0".
- NUM_DIGITS=1: every tick is a frame boundary. The guard cycle still applies.

Optional Feature:
SEG_BLINK_EN
- Defined:
  - Adds input blink_mask [NUM_DIGITS] (level) and localparam BLINK_FRAMES=64.
  - A frame counter toggles blink_phase every BLINK_FRAMES frame boundaries; reset phase = on.
  - During the off phase, masked digits drive seg=7'h7F and dp=1.
  - Frame counter and phase reset with rst.
- Undefined: no port, no counter; behaviour identical to the macro-defined build with blink_mask=0.

Decomposition:
- Package seg7_pkg holds:
  - SEG_OFF = 7'h7F constant.
  - 16-entry font constant array.
  - Function hex_to_seg(logic [3:0]).
  - typedef digit_idx_t, sized for NUM_DIGITS up to 8.
- Sub-module seg7_hex_font: combinational nibble->7-bit lookup built on the package function. Instantiated once, on the muxed nibble.
- The top level owns prescaler, index, guard, load/shadow, blanking and blink.

Test Plan:
- Reset check (NUM_DIGITS=4, CLK_DIV=4):
  - Stimulus: hold rst 3 cycles, release.
  - Response: seg=7F, an=F, dp=1 during reset. The first guard cycle occurs 4 cycles after release. an then walks E,D,B,7 with a guard of F between slots. frame_done pulses every 16 cycles.
- Load at frame boundary: load value=16'h12AF at a frame-boundary cycle. The next frame shows digit0=0E, digit1=08, digit2=24, digit3=79.
- Mid-frame loads:
  - Stimulus: in one frame, load 16'h1111 then 16'h2222.
  - Response: the remainder of the frame shows old data; the next frame shows all 24. 1111 is never displayed.
- Leading-zero blanking: blank_lz=1 with value 16'h0030 gives digits 3,2=7F, digit1=30, digit0=40. Value 0 gives only digit0=40.
- Decimal points and mid-frame reset:
  - Stimulus: dp_in=4'b0101 loaded, then rst pulsed in the middle of a frame.
  - Response: dp=0 on digits 0 and 2 before the reset. Reset returns all outputs to reset values next cycle and clears shadow to 0000.
- SEG_BLINK_EN:
  - Stimulus: blink_mask=4'b0010.
  - Response: digit1 goes blank for 64 frames and visible for 64 frames. The other digits are unaffected.

Source files
------------

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared seven-segment constants, font table and digit index type
package seg7_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Active-low a..g font, entry 15 first so FONT[n] selects nibble n
    localparam logic [15:0][6:0] FONT = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    typedef logic [2:0] digit_idx_t;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        return FONT[nibble];
    endfunction

endpackage

// File: rtl/seg7_hex_font.sv
// rtl/seg7_hex_font.sv - combinational hex nibble to active-low segment lookup
module seg7_hex_font
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/seven_segment_scan.sv
// rtl/seven_segment_scan.sv - multiplexed hex display scanner; optional SEG_BLINK_EN adds per-digit blink
module seven_segment_scan
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_DIV    = 50000
)
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
`ifdef SEG_BLINK_EN
    input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int PW = $clog2(CLK_DIV);

    logic [PW-1:0]           presc;
    digit_idx_t              idx, idx_nxt;
    logic                    tick, boundary;
    logic [4*NUM_DIGITS-1:0] pend_val, shadow_val, shadow_val_nxt;
    logic [NUM_DIGITS-1:0]   pend_dp, shadow_dp, shadow_dp_nxt;
    logic                    pend_valid;
    logic [NUM_DIGITS-1:0]   zero_from;
    logic [3:0]              nib;
    logic                    dp_sel, lz_blank, masked;
    logic [6:0]              font_seg, seg_nxt;
    logic                    dp_nxt;

    assign tick     = (presc == PW'(CLK_DIV - 1));
    assign boundary = tick && (idx == digit_idx_t'(NUM_DIGITS - 1));

`ifdef SEG_BLINK_EN
    localparam int BLINK_FRAMES = 64;
    logic [5:0] blink_cnt;
    logic       blink_on, blink_on_nxt;

    always_comb begin
        blink_on_nxt = blink_on;
        if (boundary && blink_cnt == 6'(BLINK_FRAMES - 1))
            blink_on_nxt = !blink_on;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else begin
            blink_on <= blink_on_nxt;
            if (boundary)
                blink_cnt <= (blink_cnt == 6'(BLINK_FRAMES - 1)) ? '0 : blink_cnt + 6'd1;
        end
    end
`endif

    // seg/dp are computed from the post-edge index and shadow so they settle during the guard
    always_comb begin
        idx_nxt = idx;
        if (tick)
            idx_nxt = boundary ? '0 : idx + digit_idx_t'(1);

        shadow_val_nxt = shadow_val;
        shadow_dp_nxt  = shadow_dp;
        if (boundary && load) begin
            shadow_val_nxt = value;
            shadow_dp_nxt  = dp_in;
        end else if (boundary && pend_valid) begin
            shadow_val_nxt = pend_val;
            shadow_dp_nxt  = pend_dp;
        end

        zero_from = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            if (k == NUM_DIGITS - 1)
                zero_from[k] = (shadow_val_nxt[4*k +: 4] == 4'h0);
            else
                zero_from[k] = zero_from[k+1] && (shadow_val_nxt[4*k +: 4] == 4'h0);
        end

        nib      = '0;
        dp_sel   = 1'b0;
        lz_blank = 1'b0;
        masked   = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (digit_idx_t'(k) == idx_nxt) begin
                nib      = shadow_val_nxt[4*k +: 4];
                dp_sel   = shadow_dp_nxt[k];
                lz_blank = (k != 0) && zero_from[k];
`ifdef SEG_BLINK_EN
                masked   = !blink_on_nxt && blink_mask[k];
`endif
            end
        end

        seg_nxt = (masked || (blank_lz && lz_blank)) ? SEG_OFF : font_seg;
        dp_nxt  = masked ? 1'b1 : !dp_sel;
    end

    seg7_hex_font u_font (
        .nibble (nib),
        .seg    (font_seg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            presc      <= '0;
            idx        <= '0;
            pend_val   <= '0;
            pend_dp    <= '0;
            pend_valid <= 1'b0;
            shadow_val <= '0;
            shadow_dp  <= '0;
            seg        <= SEG_OFF;
            dp         <= 1'b1;
            an         <= '1;
            frame_done <= 1'b0;
        end else begin
            presc      <= tick ? '0 : presc + PW'(1);
            idx        <= idx_nxt;
            shadow_val <= shadow_val_nxt;
            shadow_dp  <= shadow_dp_nxt;
            if (load && !boundary) begin
                pend_val   <= value;
                pend_dp    <= dp_in;
                pend_valid <= 1'b1;
            end else if (boundary) begin
                pend_valid <= 1'b0;
            end
            an         <= tick ? '1 : ~(NUM_DIGITS'(1) << idx);
            seg        <= seg_nxt;
            dp         <= dp_nxt;
            frame_done <= boundary;
        end
    end

endmodule
